// File: rtl/processing_element.sv
// Weight-stationary systolic processing element.
// A weight is captured on a load cycle; each compute cycle multiplies the
// streaming operand by that weight, adds the upstream partial sum and
// saturates the result to DATA_W bits. The operand is forwarded one cycle late.
module processing_element #(
    parameter int DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     load,
    input  logic signed [DATA_W-1:0] input_byte,
    input  logic signed [DATA_W-1:0] partial_in,
    output logic signed [DATA_W-1:0] partial_out,
    output logic signed [DATA_W-1:0] operand_out
);

    // Clamp a (2*DATA_W+1)-bit signed sum into the DATA_W-bit signed range.
    // The sum fits only when all bits from the MSB down to bit DATA_W-1 agree.
    function automatic logic [DATA_W-1:0] sat_fn(input logic [2*DATA_W:0] sum);
        logic [DATA_W+1:0] upper;
        upper = sum[2*DATA_W:DATA_W-1];
        if ((upper == {(DATA_W+2){1'b0}}) || (upper == {(DATA_W+2){1'b1}})) begin
            return sum[DATA_W-1:0];
        end else if (sum[2*DATA_W]) begin
            return {1'b1, {(DATA_W-1){1'b0}}};
        end else begin
            return {1'b0, {(DATA_W-1){1'b1}}};
        end
    endfunction

    logic [DATA_W-1:0]   r_weight;
    logic [DATA_W-1:0]   r_partial;
    logic [DATA_W-1:0]   r_operand;

    logic [2*DATA_W-1:0] w_weight_ext;
    logic [2*DATA_W-1:0] w_operand_ext;
    logic [2*DATA_W-1:0] w_product;
    logic [2*DATA_W:0]   w_partial_ext;
    logic [2*DATA_W:0]   w_sum;
    logic [DATA_W-1:0]   w_sat;

    // Sign-extend, multiply at full width, add the upstream partial sum and saturate.
    always_comb begin
        w_weight_ext  = {{DATA_W{r_weight[DATA_W-1]}}, r_weight};
        w_operand_ext = {{DATA_W{input_byte[DATA_W-1]}}, input_byte};
        // Low 2*DATA_W bits of the extended product equal the exact signed product.
        w_product     = w_weight_ext * w_operand_ext;
        w_partial_ext = {{(DATA_W+1){partial_in[DATA_W-1]}}, partial_in};
        w_sum         = {w_product[2*DATA_W-1], w_product} + w_partial_ext;
        w_sat         = sat_fn(w_sum);
    end

    // Weight capture on load; MAC result and operand forwarding on compute.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_weight  <= {DATA_W{1'b0}};
            r_partial <= {DATA_W{1'b0}};
            r_operand <= {DATA_W{1'b0}};
        end else if (load) begin
            r_weight  <= input_byte;
            r_partial <= {DATA_W{1'b0}};
            r_operand <= {DATA_W{1'b0}};
        end else begin
            r_weight  <= r_weight;
            r_partial <= w_sat;
            r_operand <= input_byte;
        end
    end

    assign partial_out = r_partial;
    assign operand_out = r_operand;

endmodule

// File: tb/tb_processing_element.sv
// Scoreboard bench for processing_element: the driver pushes hand-computed
// expectations, a monitor pops and compares after each rising edge.
module tb_processing_element;

    localparam int DATA_W = 8;

    logic                     clk;
    logic                     n_rst;
    logic                     load;
    logic signed [DATA_W-1:0] input_byte;
    logic signed [DATA_W-1:0] partial_in;
    logic signed [DATA_W-1:0] partial_out;
    logic signed [DATA_W-1:0] operand_out;

    typedef struct {
        string            name;
        logic [DATA_W-1:0] exp_partial;
        logic [DATA_W-1:0] exp_operand;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    processing_element #(.DATA_W(DATA_W)) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .load       (load),
        .input_byte (input_byte),
        .partial_in (partial_in),
        .partial_out(partial_out),
        .operand_out(operand_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one cycle of stimulus at the falling edge and record the expected outputs.
    task automatic drive(input logic rst_v, input logic l, input int in_v, input int p_v,
                         input int ep, input int eo, input string nm);
        exp_t e;
        @(negedge clk);
        n_rst      = rst_v;
        load       = l;
        input_byte = DATA_W'(in_v);
        partial_in = DATA_W'(p_v);
        e.name        = nm;
        e.exp_partial = DATA_W'(ep);
        e.exp_operand = DATA_W'(eo);
        exp_q.push_back(e);
    endtask

    // Monitor: after each rising edge, check the outputs for the pending expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_checks++;
                if (partial_out !== e.exp_partial) begin
                    n_fail++;
                    $display("FAIL %s partial_out: got %h expected %h", e.name, partial_out, e.exp_partial);
                end
                n_checks++;
                if (operand_out !== e.exp_operand) begin
                    n_fail++;
                    $display("FAIL %s operand_out: got %h expected %h", e.name, operand_out, e.exp_operand);
                end
            end
        end
    end

    initial begin
        n_rst      = 1'b0;
        load       = 1'b1;
        input_byte = 8'h55;
        partial_in = 8'h11;

        // Reset held for two clocks with load asserted: everything stays zero.
        drive(1'b0, 1'b1, 8'h55, 8'h11, 0, 0, "rst_hold0");
        drive(1'b0, 1'b1, 8'h55, 8'h11, 0, 0, "rst_hold1");
        // First edge after reset, weight 0: partial passes through.
        drive(1'b1, 1'b0, 9, 4, 4, 9, "post_rst");

        // Basic MAC.
        drive(1'b1, 1'b1, 2, 77, 0, 0, "load2");
        drive(1'b1, 1'b0, 5, 6, 16, 5, "mac_basic");

        // Signed cases.
        drive(1'b1, 1'b1, -1, 0, 0, 0, "load_m1");
        drive(1'b1, 1'b0, 7, 6, -1, 7, "signed1");
        drive(1'b1, 1'b1, -5, 0, 0, 0, "load_m5");
        drive(1'b1, 1'b0, 6, -7, -37, 6, "signed2");

        // Saturation in both directions.
        drive(1'b1, 1'b1, -128, 0, 0, 0, "load_m128");
        drive(1'b1, 1'b0, -128, 100, 127, -128, "sat_pos");
        drive(1'b1, 1'b0, 127, 3, -128, 127, "sat_neg");

        // Streaming with the weight held.
        drive(1'b1, 1'b1, 4, 0, 0, 0, "load4");
        drive(1'b1, 1'b0, -4, 14, -2, -4, "stream0");
        drive(1'b1, 1'b0, -10, 14, -26, -10, "stream1");
        drive(1'b1, 1'b0, -15, 2, -58, -15, "stream2");
        drive(1'b1, 1'b0, 50, -10, 127, 50, "stream3");

        // Back-to-back loads: last one wins.
        drive(1'b1, 1'b1, 10, 5, 0, 0, "load10");
        drive(1'b1, 1'b1, 3, 5, 0, 0, "load3");
        drive(1'b1, 1'b0, 2, 1, 7, 2, "b2b_mac");

        // Mid-stream asynchronous reset discards the weight.
        drive(1'b1, 1'b1, 4, 0, 0, 0, "load4b");
        drive(1'b1, 1'b0, 1, 0, 4, 1, "pre_arst");
        @(posedge clk);
        #5;
        n_rst = 1'b0;
        #1;
        n_checks++;
        if (partial_out !== 8'h00) begin
            n_fail++;
            $display("FAIL arst_partial: got %h expected 00", partial_out);
        end
        n_checks++;
        if (operand_out !== 8'h00) begin
            n_fail++;
            $display("FAIL arst_operand: got %h expected 00", operand_out);
        end
        drive(1'b1, 1'b0, 3, 5, 5, 3, "post_arst");

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10; i++) begin
            if (exp_q.size() > 0) @(posedge clk);
        end
        #5;
        if (exp_q.size() > 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/processing_element.md
PROCESSING_ELEMENT -- requirements
Module: processing_element

Interface
REQ-001 Parameter: DATA_W, default 8, width of every data port, weight and operand register; all values are two's-complement signed.
REQ-002 Port: clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 Port: n_rst  input  1  reset, asynchronous, active-low.
REQ-004 Port: load  input  1  1 = capture input_byte as the stationary weight this cycle; 0 = compute.
REQ-005 Port: input_byte  input  DATA_W  signed weight value when load=1; signed streaming operand when load=0.
REQ-006 Port: partial_in  input  DATA_W  signed partial sum arriving from the upstream PE.
REQ-007 Port: partial_out  output  DATA_W  registered signed partial sum sent to the downstream PE.
REQ-008 Port: operand_out  output  DATA_W  registered copy of the operand, forwarded to the neighbouring PE.

Function
REQ-009 The block SHALL hold three registers: weight, partial_out and operand_out, each DATA_W bits.
REQ-010 Rising edge with load=1: weight <= input_byte; partial_out <= 0; operand_out <= 0; partial_in is ignored.
REQ-011 Rising edge with load=0: weight holds its value; operand_out <= input_byte; partial_out <= sat(weight*input_byte + partial_in).
REQ-012 Arithmetic: signed product at 2*DATA_W bits; partial_in sign-extended; sum at 2*DATA_W+1 bits, so no intermediate overflow.
REQ-013 sat(): sum > 2^(DATA_W-1)-1 gives 0x7F (127); sum < -2^(DATA_W-1) gives 0x80 (-128); otherwise the low DATA_W bits.
REQ-014 Latency: exactly one clock from input sampling to partial_out/operand_out; no combinational path from any input to any output.
REQ-015 Throughput: one MAC per clock while load=0; no handshake, no stall; a new operand is accepted every cycle.
REQ-016 The weight persists across any number of compute cycles until the next load=1 edge.
REQ-017 Back-to-back load cycles: the last captured value wins; outputs stay 0 for every load cycle.
REQ-018 The first compute cycle after a load SHALL use the newly loaded weight.
REQ-019 No FSM: behaviour is fully determined by load on each edge.

Reset
REQ-020 n_rst=0 SHALL immediately, independent of clk, clear weight, partial_out and operand_out to 0.
REQ-021 While n_rst=0, registers stay 0 regardless of load and data inputs.
REQ-022 After n_rst deasserts, the first rising edge operates per REQ-010/011.
REQ-023 Before any load after reset, compute cycles use weight 0, so partial_out = partial_in.
REQ-024 Reset asserted mid-stream discards the weight; a fresh load is required.

Verification
REQ-025 Reset: assert n_rst for 2 clocks -> partial_out=0, operand_out=0; then load=0, input 9, partial_in 4 -> partial_out=4, operand_out=9.
REQ-026 Basic MAC: load 2 -> outputs 0; next cycle load=0, input 5, partial_in 6 -> partial_out=16 (0x10), operand_out=5.
REQ-027 Signed: load 0xFF (-1); input 7, partial_in 6 -> partial_out=0xFF (-1), operand_out=7.
REQ-028 Signed 2: load -5; input 6, partial_in -7 -> partial_out=0xDB (-37), operand_out=6.
REQ-029 Saturation: load -128; input -128, partial_in 100 -> 0x7F, operand_out=0x80; next cycle input 127, partial_in 3 -> 0x80, operand_out=127.
REQ-030 Streaming/hold: load 4; then inputs -4, -10, -15, 50 with partial_in 14, 14, 2, -10 on consecutive cycles -> partial_out -2, -26, -58, 127 (saturated), operand_out following input_byte one cycle late.
